grid_tile_renderer: RTL and testbench

//  Parametrised, pipelined successor to the 3x3 game display path: maps VGA h_cnt/v_cnt onto a

---
 rtl/grid_tile_renderer.sv | 228 ++++++++++++++++++++++
 tb/tb_grid_tile_renderer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_tile_renderer.sv
// Grid tile renderer: maps VGA counters onto a GRID_N x GRID_N tile grid, issues sprite ROM
// addresses and produces a registered RGB444 pixel with a fixed 3-clock latency.
module grid_tile_renderer #(
  parameter int GRID_N      = 3,
  parameter int TILE_SIZE   = 140,
  parameter int GRID_X0     = 110,
  parameter int GRID_Y0     = 30,
  parameter int BORDER_W    = 2,
  parameter int IMG_SIZE    = 60,
  parameter int ANIM_FRAMES = 6,
  parameter int FRAME_DIV   = 8,
  parameter int BLINK_DIV   = 16,
  parameter int FRAME_LINE  = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  input  logic [1:0]                 game_state,
  input  logic [GRID_N*GRID_N-1:0]   fire_state,
  input  logic [GRID_N*GRID_N-1:0]   box,
  input  logic [GRID_N*GRID_N-1:0]   warning_state,
  output logic [11:0]                rom_addr,
  output logic [3:0]                 anim_frame,
  input  logic [11:0]                fire_rom_data,
  input  logic [11:0]                ct_rom_data,
  output logic [11:0]                pixel_color
);

  localparam int GRID_W  = GRID_N * TILE_SIZE;
  localparam int IMG_OFF = (TILE_SIZE - IMG_SIZE) / 2;

  typedef enum logic [1:0] {GS_INIT, GS_PLAY, GS_FINISH, GS_RSVD} game_t;
  typedef enum logic [1:0] {RG_OUT, RG_GRID, RG_BORDER, RG_SPRITE} region_t;

  typedef struct packed {
    logic       in_range;
    logic       brd;
    logic       win;
    logic [1:0] tile;
    logic [9:0] img;
  } axis_t;

  // Tile/local position along one axis via a compare chain against tile boundaries.
  function automatic axis_t decode_axis(input logic [9:0] cnt, input logic [9:0] origin);
    axis_t       a;
    logic [10:0] rel;
    logic [9:0]  loc;
    rel = {1'b0, cnt} - {1'b0, origin};
    loc = rel[9:0];
    a   = '0;
    for (int unsigned k = 1; k < GRID_N; k++) begin
      if (rel >= 11'(k * TILE_SIZE)) begin
        a.tile = 2'(k);
        loc    = 10'(rel - 11'(k * TILE_SIZE));
      end
    end
    a.in_range = (cnt >= origin) && (rel < 11'(GRID_W));
    a.brd      = a.in_range && ((loc < 10'(BORDER_W)) || (loc == 10'(TILE_SIZE - 1)) ||
                                (rel >= 11'(GRID_W - BORDER_W)));
    a.win      = a.in_range && (loc >= 10'(IMG_OFF)) && (loc < 10'(IMG_OFF + IMG_SIZE));
    a.img      = loc - 10'(IMG_OFF);
    return a;
  endfunction

  axis_t       ax;
  axis_t       ay;
  region_t     region_c;
  logic [3:0]  idx_c;
  logic [11:0] addr_c;
  logic [15:0] box_ext;
  logic [15:0] fire_ext;
  logic [15:0] warn_ext;

  logic        frame_cond;
  logic        frame_cond_q;
  logic        frame_evt;
  logic [7:0]  div_cnt;
  logic [7:0]  blink_cnt;
  logic        blink_phase;

  logic        s1_valid;
  logic        s1_box;
  logic        s1_fire;
  logic        s1_warn;
  region_t     s1_region;
  game_t       s1_state;

  logic        s2_valid;
  logic        s2_box;
  logic        s2_fire;
  logic        s2_warn;
  region_t     s2_region;
  game_t       s2_state;

  logic [11:0] color_c;

  assign box_ext  = 16'(box);
  assign fire_ext = 16'(fire_state);
  assign warn_ext = 16'(warning_state);

  always_comb begin
    ax       = decode_axis(h_cnt, 10'(GRID_X0));
    ay       = decode_axis(v_cnt, 10'(GRID_Y0));
    idx_c    = 4'({2'b0, ay.tile} * 4'(GRID_N)) + {2'b0, ax.tile};
    region_c = RG_OUT;
    if (ax.in_range && ay.in_range) begin
      if (ax.brd || ay.brd) begin
        region_c = RG_BORDER;
      end else if (ax.win && ay.win) begin
        region_c = RG_SPRITE;
      end else begin
        region_c = RG_GRID;
      end
    end
    addr_c = '0;
    if (region_c == RG_SPRITE) begin
      addr_c = 12'({2'b0, ay.img} * 12'(IMG_SIZE)) + {2'b0, ax.img};
    end
  end

  // Frame event fires once per hold of the frame-line sample, however long h_cnt stays at 0.
  assign frame_cond = (v_cnt == 10'(FRAME_LINE)) && (h_cnt == '0);
  assign frame_evt  = frame_cond && !frame_cond_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cond_q <= 1'b0;
      div_cnt      <= '0;
      blink_cnt    <= '0;
      anim_frame   <= '0;
      blink_phase  <= 1'b0;
    end else begin
      frame_cond_q <= frame_cond;
      if (frame_evt) begin
        if (div_cnt == 8'(FRAME_DIV - 1)) begin
          div_cnt <= '0;
          if (anim_frame == 4'(ANIM_FRAMES - 1)) begin
            anim_frame <= '0;
          end else begin
            anim_frame <= anim_frame + 4'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (blink_cnt == 8'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_box    <= 1'b0;
      s1_fire   <= 1'b0;
      s1_warn   <= 1'b0;
      s1_region <= RG_OUT;
      s1_state  <= GS_INIT;
      s2_valid  <= 1'b0;
      s2_box    <= 1'b0;
      s2_fire   <= 1'b0;
      s2_warn   <= 1'b0;
      s2_region <= RG_OUT;
      s2_state  <= GS_INIT;
    end else begin
      rom_addr  <= addr_c;
      s1_valid  <= valid;
      s1_box    <= box_ext[idx_c];
      s1_fire   <= fire_ext[idx_c];
      s1_warn   <= warn_ext[idx_c] && blink_phase;
      s1_region <= region_c;
      s1_state  <= game_t'(game_state);
      s2_valid  <= s1_valid;
      s2_box    <= s1_box;
      s2_fire   <= s1_fire;
      s2_warn   <= s1_warn;
      s2_region <= s1_region;
      s2_state  <= s1_state;
    end
  end

  always_comb begin
    color_c = 12'h000;
    if (s2_valid) begin
      unique case (s2_state)
        GS_INIT: begin
          if (s2_region == RG_BORDER)   color_c = 12'hFFF;
          else if (s2_region == RG_OUT) color_c = 12'h222;
          else                          color_c = 12'h000;
        end
        GS_PLAY: begin
          unique case (s2_region)
            RG_BORDER: color_c = s2_warn ? 12'hFF0 : 12'hFFF;
            RG_SPRITE: begin
              if (s2_box)       color_c = ct_rom_data;
              else if (s2_fire) color_c = fire_rom_data;
              else              color_c = 12'h000;
            end
            RG_GRID:   color_c = 12'h000;
            RG_OUT:    color_c = 12'h222;
          endcase
        end
        GS_FINISH: begin
          if (s2_region == RG_BORDER)   color_c = 12'h444;
          else if (s2_region == RG_OUT) color_c = 12'h222;
          else                          color_c = 12'h111;
        end
        GS_RSVD: color_c = 12'h222;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_color <= 12'h000;
    end else begin
      pixel_color <= color_c;
    end
  end

endmodule

// File: tb/tb_grid_tile_renderer.sv
// Directed bench for grid_tile_renderer: table of pixel vectors plus hand-written frame,
// blink, streaming and reset sequences. Sprite ROMs are modelled as 1-cycle XOR patterns.
module tb_grid_tile_renderer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [1:0]  game_state;
  logic [8:0]  fire_state;
  logic [8:0]  box;
  logic [8:0]  warning_state;
  logic [11:0] rom_addr;
  logic [3:0]  anim_frame;
  logic [11:0] fire_rom_data;
  logic [11:0] ct_rom_data;
  logic [11:0] pixel_color;

  int checks   = 0;
  int failures = 0;

  grid_tile_renderer #(
    .GRID_N(3), .TILE_SIZE(140), .GRID_X0(110), .GRID_Y0(30), .BORDER_W(2),
    .IMG_SIZE(60), .ANIM_FRAMES(6), .FRAME_DIV(8), .BLINK_DIV(16), .FRAME_LINE(480)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .game_state(game_state), .fire_state(fire_state), .box(box),
    .warning_state(warning_state), .rom_addr(rom_addr), .anim_frame(anim_frame),
    .fire_rom_data(fire_rom_data), .ct_rom_data(ct_rom_data), .pixel_color(pixel_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ct_rom_data   = '0;
    fire_rom_data = '0;
  end
  always @(posedge clk) begin
    ct_rom_data   <= rom_addr ^ 12'hC3C;
    fire_rom_data <= rom_addr ^ 12'h5A5;
  end

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        vld;
    logic [1:0]  st;
    logic [8:0]  bx;
    logic [8:0]  fr;
    logic [8:0]  wr;
    logic [11:0] addr;
    logic [11:0] pix;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int h, input int v, input logic vld, input logic [1:0] st,
                     input logic [8:0] bx, input logic [8:0] fr, input logic [8:0] wr,
                     input logic [11:0] addr, input logic [11:0] pix);
    vec_t e;
    e.h = 10'(h); e.v = 10'(v); e.vld = vld; e.st = st;
    e.bx = bx; e.fr = fr; e.wr = wr; e.addr = addr; e.pix = pix;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic vld, input logic [1:0] st,
                       input logic [8:0] bx, input logic [8:0] fr, input logic [8:0] wr);
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vld; game_state = st;
    box = bx; fire_state = fr; warning_state = wr;
  endtask

  int frames = 0;

  task automatic frame_step();
    drive(0, 480, 1'b0, 2'd1, '0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    v_cnt = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    frames++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // h, v, valid, state, box, fire, warning, rom_addr, pixel
    add(290, 210, 1, 2'd1, 9'h010, 9'h000, 9'h000, 12'h000, 12'hC3C);
    add(349, 269, 1, 2'd1, 9'h010, 9'h000, 9'h000, 12'hE0F, 12'h233);
    add(350, 210, 1, 2'd1, 9'h010, 9'h000, 9'h000, 12'h000, 12'h000);
    add(290, 210, 1, 2'd1, 9'h010, 9'h010, 9'h000, 12'h000, 12'hC3C);
    add(290, 210, 1, 2'd1, 9'h000, 9'h010, 9'h000, 12'h000, 12'h5A5);
    add(290, 210, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'h000);
    add(110,  30, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'hFFF);
    add(249, 100, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'hFFF);
    add(109,  30, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'h222);
    add(110,  30, 0, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'h000);
    add(200, 100, 1, 2'd0, 9'h000, 9'h000, 9'h000, 12'h73A, 12'h000);
    add(110,  30, 1, 2'd0, 9'h000, 9'h000, 9'h000, 12'h000, 12'hFFF);
    add(109,  30, 1, 2'd0, 9'h000, 9'h000, 9'h000, 12'h000, 12'h222);
    add(200, 100, 1, 2'd2, 9'h000, 9'h000, 9'h000, 12'h73A, 12'h111);
    add(110,  30, 1, 2'd2, 9'h000, 9'h000, 9'h000, 12'h000, 12'h444);
    add(109,  30, 1, 2'd2, 9'h000, 9'h000, 9'h000, 12'h000, 12'h222);
    add(200, 100, 1, 2'd3, 9'h000, 9'h000, 9'h000, 12'h73A, 12'h222);
    add(529, 449, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'hFFF);
    add(530,  30, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'h222);
    add(110, 450, 1, 2'd1, 9'h000, 9'h000, 9'h000, 12'h000, 12'h222);
    add(251, 171, 1, 2'd1, 9'h000, 9'h000, 9'h010, 12'h000, 12'hFFF);
    add(430, 350, 1, 2'd1, 9'h100, 9'h000, 9'h000, 12'h000, 12'hC3C);
    add(430, 350, 1, 2'd1, 9'h010, 9'h000, 9'h000, 12'h000, 12'h000);
    add(430, 210, 1, 2'd1, 9'h020, 9'h000, 9'h000, 12'h000, 12'hC3C);
    add(430, 210, 1, 2'd1, 9'h008, 9'h000, 9'h000, 12'h000, 12'h000);
    add(150,  70, 1, 2'd1, 9'h001, 9'h000, 9'h000, 12'h000, 12'hC3C);
    add(260, 190, 1, 2'd1, 9'h1FF, 9'h000, 9'h000, 12'h000, 12'h000);
    add(200, 100, 0, 2'd0, 9'h000, 9'h000, 9'h000, 12'h73A, 12'h000);

    rst = 1'b1;
    drive(0, 0, 1'b0, 2'd0, '0, '0, '0);
    #3;
    check("reset pixel", pixel_color, 12'h000);
    check("reset addr", rom_addr, 12'h000);
    check("reset anim", 12'(anim_frame), 12'h000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(int'(vecs[i].h), int'(vecs[i].v), vecs[i].vld, vecs[i].st,
            vecs[i].bx, vecs[i].fr, vecs[i].wr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d addr", i), rom_addr, vecs[i].addr);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d pixel", i), pixel_color, vecs[i].pix);
    end

    // Back-to-back pixels with flags changing every cycle.
    begin
      logic [11:0] exp_stream [4];
      exp_stream[0] = 12'hC3C;
      exp_stream[1] = 12'h000;
      exp_stream[2] = 12'hC3E;
      exp_stream[3] = 12'h5A6;
      for (int j = 0; j < 6; j++) begin
        if (j == 0) drive(290, 210, 1'b1, 2'd1, 9'h010, 9'h000, 9'h000);
        if (j == 1) drive(291, 210, 1'b1, 2'd1, 9'h000, 9'h000, 9'h000);
        if (j == 2) drive(292, 210, 1'b1, 2'd1, 9'h010, 9'h000, 9'h000);
        if (j == 3) drive(293, 210, 1'b1, 2'd1, 9'h000, 9'h010, 9'h000);
        @(posedge clk);
        #1;
        if (j >= 2) check($sformatf("stream%0d pixel", j - 2), pixel_color, exp_stream[j - 2]);
      end
    end

    // Frame-locked animation and warning blink.
    for (int f = 1; f <= 48; f++) begin
      frame_step();
      check($sformatf("anim f%0d", frames), 12'(anim_frame), 12'((frames / 8) % 6));
      drive(110, 30, 1'b1, 2'd1, '0, '0, 9'h001);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("blink tile0 f%0d", frames), pixel_color,
            (((frames / 16) % 2) == 1) ? 12'hFF0 : 12'hFFF);
      if ((frames % 8) == 0) begin
        drive(250, 30, 1'b1, 2'd1, '0, '0, 9'h001);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("blink tile1 f%0d", frames), pixel_color, 12'hFFF);
      end
    end

    for (int f = 0; f < 8; f++) frame_step();
    check("anim f56", 12'(anim_frame), 12'h001);

    // Asynchronous reset in the middle of a line.
    drive(349, 269, 1'b1, 2'd1, 9'h010, 9'h000, 9'h000);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset pixel", pixel_color, 12'h233);
    #2;
    rst = 1'b1;
    #1;
    check("midline reset pixel", pixel_color, 12'h000);
    check("midline reset addr", rom_addr, 12'h000);
    check("midline reset anim", 12'(anim_frame), 12'h000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset pixel +%0d", j), pixel_color, (j == 3) ? 12'h233 : 12'h000);
    end
    drive(110, 30, 1'b1, 2'd1, '0, '0, 9'h001);
    repeat (3) @(posedge clk);
    #1;
    check("post-reset blink phase", pixel_color, 12'hFFF);
    check("post-reset anim", 12'(anim_frame), 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
